// File: rtl/i3c_rstseq_pkg.sv
// Shared types and defaults for the I3C reset sequencer.
package i3c_rstseq_pkg;

    localparam int unsigned CntWidth             = 16;
    localparam int unsigned StateWidth           = 3;
    localparam int unsigned DefResetHoldCycles   = 16;
    localparam int unsigned DefDoneTimeoutCycles = 1024;

    typedef enum logic [StateWidth-1:0] {
        StIdle     = 3'd0,
        StAssert   = 3'd1,
        StRelease  = 3'd2,
        StDone     = 3'd3,
        StEscalate = 3'd4
    } rstseq_state_e;

endpackage

// File: rtl/i3c_reset_sequencer_if.sv
// Core-facing signal bundle of the reset sequencer; master is the I3C core / SoC side.
interface i3c_reset_sequencer_if;
    import i3c_rstseq_pkg::*;

    logic                  peripheral_reset;
    logic                  escalated_reset;
    logic                  recovery_image_activated;
    logic                  periph_ready;
    logic                  sys_reset_ack;
    logic                  periph_rst_n;
    logic                  peripheral_reset_done;
    logic                  sys_reset_req;
    logic                  busy;
    logic                  timeout;
    logic [StateWidth-1:0] state;

    modport master (
        output peripheral_reset, escalated_reset, recovery_image_activated, periph_ready,
               sys_reset_ack,
        input  periph_rst_n, peripheral_reset_done, sys_reset_req, busy, timeout, state
    );

    modport slave (
        input  peripheral_reset, escalated_reset, recovery_image_activated, periph_ready,
               sys_reset_ack,
        output periph_rst_n, peripheral_reset_done, sys_reset_req, busy, timeout, state
    );

endinterface

// File: rtl/i3c_rstseq_cnt.sv
// 16-bit load/decrement counter with zero flag; decrement saturates at zero.
module i3c_rstseq_cnt
    import i3c_rstseq_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [CntWidth-1:0] load_val_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] count_o,
    output logic                zero_o
);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/i3c_reset_sequencer.sv
// Peripheral reset sequencer driven by the I3C core: hold, release, ready wait, escalation.
// Optional ready-wait timeout is built when I3C_RSTSEQ_TIMEOUT_EN is defined.
module i3c_reset_sequencer
    import i3c_rstseq_pkg::*;
#(
    parameter int unsigned ResetHoldCycles   = DefResetHoldCycles,
    parameter int unsigned DoneTimeoutCycles = DefDoneTimeoutCycles
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  peripheral_reset_i,
    input  logic                  escalated_reset_i,
    input  logic                  recovery_image_activated_i,
    input  logic                  periph_ready_i,
    input  logic                  sys_reset_ack_i,
    output logic                  periph_rst_no,
    output logic                  peripheral_reset_done_o,
    output logic                  sys_reset_req_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic [StateWidth-1:0] state_o
);

    rstseq_state_e       state_q, state_d;
    logic                per_q, rec_q;
    logic                trigger, timeout_hit;
    logic                rst_n_q, done_q, sys_req_q, busy_q;
    logic                hold_load, hold_dec, hold_zero, hold_expired;
    logic [CntWidth-1:0] hold_cnt;
    logic                wait_expired;

    assign trigger = (peripheral_reset_i & ~per_q) | (recovery_image_activated_i & ~rec_q);

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        if (escalated_reset_i) begin
            state_d = StEscalate;
        end else begin
            case (state_q)
                StIdle:     if (trigger) state_d = StAssert;
                StAssert:   if (!trigger && hold_expired) state_d = StRelease;
                StRelease: begin
                    if (trigger) begin
                        state_d = StAssert;
                    end else if (periph_ready_i) begin
                        state_d = StDone;
                    end else if (wait_expired) begin
                        state_d     = StEscalate;
                        timeout_hit = 1'b1;
                    end
                end
                StDone:     if (!peripheral_reset_i) state_d = StIdle;
                StEscalate: if (sys_reset_ack_i) state_d = StIdle;
                default:    state_d = StIdle;
            endcase
        end
    end

    // Counter holds the remaining low cycles including the current one, so exit at 1.
    assign hold_load    = (state_d == StAssert) && ((state_q != StAssert) || trigger);
    assign hold_dec     = (state_q == StAssert) && !hold_load;
    assign hold_expired = (hold_cnt == CntWidth'(1)) || hold_zero;

    i3c_rstseq_cnt u_hold_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (hold_load),
        .load_val_i (CntWidth'(ResetHoldCycles)),
        .dec_i      (hold_dec),
        .count_o    (hold_cnt),
        .zero_o     (hold_zero)
    );

`ifdef I3C_RSTSEQ_TIMEOUT_EN
    logic                wait_load, wait_zero, timeout_q;
    logic [CntWidth-1:0] wait_cnt;

    assign wait_load    = (state_d == StRelease) && (state_q != StRelease);
    assign wait_expired = (wait_cnt == CntWidth'(1)) || wait_zero;

    i3c_rstseq_cnt u_wait_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (wait_load),
        .load_val_i (CntWidth'(DoneTimeoutCycles)),
        .dec_i      (state_q == StRelease),
        .count_o    (wait_cnt),
        .zero_o     (wait_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_cfg;

    assign wait_expired = 1'b0;
    assign timeout_o    = 1'b0;
    assign unused_cfg   = timeout_hit ^ (^CntWidth'(DoneTimeoutCycles));
`endif

    // Output flops take the next state so every output is a register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            per_q     <= 1'b0;
            rec_q     <= 1'b0;
            rst_n_q   <= 1'b0;
            done_q    <= 1'b0;
            sys_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= peripheral_reset_i;
            rec_q     <= recovery_image_activated_i;
            rst_n_q   <= !((state_d == StAssert) || (state_d == StEscalate));
            done_q    <= (state_d == StDone);
            sys_req_q <= (state_d == StEscalate);
            busy_q    <= (state_d != StIdle);
        end
    end

    assign periph_rst_no           = rst_n_q;
    assign peripheral_reset_done_o = done_q;
    assign sys_reset_req_o         = sys_req_q;
    assign busy_o                  = busy_q;
    assign state_o                 = state_q;

endmodule

// File: tb/tb_i3c_reset_sequencer.sv
// Randomized bench for i3c_reset_sequencer against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_i3c_reset_sequencer;

    localparam int unsigned Hold = 4;
    localparam int unsigned Tmo  = 8;
`ifdef I3C_RSTSEQ_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i3c_reset_sequencer_if bus ();

    i3c_reset_sequencer #(
        .ResetHoldCycles   (Hold),
        .DoneTimeoutCycles (Tmo)
    ) dut (
        .clk_i                      (clk),
        .rst_ni                     (rst_n),
        .peripheral_reset_i         (bus.peripheral_reset),
        .escalated_reset_i          (bus.escalated_reset),
        .recovery_image_activated_i (bus.recovery_image_activated),
        .periph_ready_i             (bus.periph_ready),
        .sys_reset_ack_i            (bus.sys_reset_ack),
        .periph_rst_no              (bus.periph_rst_n),
        .peripheral_reset_done_o    (bus.peripheral_reset_done),
        .sys_reset_req_o            (bus.sys_reset_req),
        .busy_o                     (bus.busy),
        .timeout_o                  (bus.timeout),
        .state_o                    (bus.state)
    );

    int n_checks = 0;
    int n_bad    = 0;

    // Model: 0 idle, 1 assert, 2 release, 3 done, 4 escalate.
    int m_state, m_elapsed, m_rel;
    bit m_prev_per, m_prev_rec, m_timeout, m_in_reset;
    int low_cnt;
    bit saw_assert;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_elapsed  = 0;
        m_rel      = 0;
        m_prev_per = 1'b0;
        m_prev_rec = 1'b0;
        m_timeout  = 1'b0;
        m_in_reset = 1'b1;
    endtask

    task automatic model_step();
        bit trig;
        if (!rst_n) return;
        trig = (bus.peripheral_reset && !m_prev_per) ||
               (bus.recovery_image_activated && !m_prev_rec);
        if (bus.escalated_reset) begin
            m_state = 4;
        end else begin
            case (m_state)
                0: if (trig) begin m_state = 1; m_elapsed = 1; end
                1: begin
                    if (trig) m_elapsed = 1;
                    else if (m_elapsed == Hold) begin m_state = 2; m_rel = 1; end
                    else m_elapsed++;
                end
                2: begin
                    if (trig) begin m_state = 1; m_elapsed = 1; end
                    else if (bus.periph_ready) m_state = 3;
                    else if (TimeoutEn && m_rel == Tmo) begin m_state = 4; m_timeout = 1'b1; end
                    else m_rel++;
                end
                3: if (!bus.peripheral_reset) m_state = 0;
                default: if (bus.sys_reset_ack) m_state = 0;
            endcase
        end
        m_prev_per = bus.peripheral_reset;
        m_prev_rec = bus.recovery_image_activated;
        m_in_reset = 1'b0;
    endtask

    task automatic compare_all();
        bit low_exp;
        low_exp = m_in_reset || (m_state == 1) || (m_state == 4);
        check("state", 32'(bus.state), m_state);
        check("periph_rst_n", bus.periph_rst_n, !low_exp);
        check("done", bus.peripheral_reset_done, !m_in_reset && m_state == 3);
        check("sys_req", bus.sys_reset_req, !m_in_reset && m_state == 4);
        check("busy", bus.busy, !m_in_reset && m_state != 0);
        check("timeout", bus.timeout, m_timeout);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (!bus.periph_rst_n) low_cnt++;
        if (bus.state == 3'd1) saw_assert = 1'b1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_model_state(input int target, input int budget, input string tag);
        int left;
        left = budget;
        while (m_state != target && left > 0) begin
            tick();
            left--;
        end
        check(tag, 32'(bus.state), target);
    endtask

    task automatic pulse_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (n) begin
            @(negedge clk);
            compare_all();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bus.peripheral_reset         = 1'b0;
        bus.escalated_reset          = 1'b0;
        bus.recovery_image_activated = 1'b0;
        bus.periph_ready             = 1'b0;
        bus.sys_reset_ack            = 1'b0;
        low_cnt    = 0;
        saw_assert = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        ticks($urandom_range(1, 3));

        // Plain request, ready two cycles into release.
        low_cnt = 0;
        bus.peripheral_reset = 1'b1;
        wait_model_state(2, 20, "s1_release");
        ticks(2);
        bus.periph_ready = 1'b1;
        tick();
        bus.periph_ready = 1'b0;
        ticks($urandom_range(1, 4));
        check("s1_done_held", bus.peripheral_reset_done, 1);
        bus.peripheral_reset = 1'b0;
        ticks(2);
        check("s1_low_cycles", low_cnt, Hold);
        check("s1_idle", 32'(bus.state), 0);

        // Ready never comes.
        bus.peripheral_reset = 1'b1;
        wait_model_state(2, 20, "s2_release");
        ticks(Tmo + 3);
        check("s2_timeout", bus.timeout, TimeoutEn);
        bus.sys_reset_ack = 1'b1;
        tick();
        bus.sys_reset_ack    = 1'b0;
        bus.peripheral_reset = 1'b0;
        tick();
        check("s2_timeout_sticky", bus.timeout, TimeoutEn);
        bus.escalated_reset = 1'b1;
        tick();
        bus.escalated_reset = 1'b0;
        ticks($urandom_range(1, 3));
        bus.sys_reset_ack = 1'b1;
        tick();
        bus.sys_reset_ack = 1'b0;
        tick();
        check("s2_idle", 32'(bus.state), 0);

        // Escalation and request in the same cycle.
        saw_assert = 1'b0;
        bus.escalated_reset  = 1'b1;
        bus.peripheral_reset = 1'b1;
        tick();
        check("s3_escalate", 32'(bus.state), 4);
        bus.escalated_reset = 1'b0;
        ticks($urandom_range(1, 3));
        bus.sys_reset_ack = 1'b1;
        tick();
        bus.sys_reset_ack    = 1'b0;
        bus.peripheral_reset = 1'b0;
        tick();
        check("s3_no_assert", saw_assert, 0);

        // Recovery image retriggers two cycles into assert.
        low_cnt = 0;
        bus.peripheral_reset = 1'b1;
        ticks(2);
        bus.recovery_image_activated = 1'b1;
        wait_model_state(2, 20, "s4_release");
        check("s4_low_cycles", low_cnt, Hold + 2);
        bus.periph_ready = 1'b1;
        tick();
        bus.periph_ready             = 1'b0;
        bus.peripheral_reset         = 1'b0;
        bus.recovery_image_activated = 1'b0;
        ticks(2);

        // Reset pulse mid-sequence.
        bus.peripheral_reset = 1'b1;
        wait_model_state(2, 20, "s5_release");
        tick();
        bus.peripheral_reset = 1'b0;
        pulse_reset(2);
        ticks(3);
        check("s5_idle", 32'(bus.state), 0);

        // Long wait with ready low.
        bus.peripheral_reset = 1'b1;
        wait_model_state(2, 20, "s6_release");
        ticks(100);
        check("s6_state", 32'(bus.state), TimeoutEn ? 4 : 2);
        check("s6_timeout", bus.timeout, TimeoutEn);
        bus.peripheral_reset = 1'b0;
        bus.escalated_reset  = 1'b1;
        tick();
        bus.escalated_reset = 1'b0;
        bus.sys_reset_ack   = 1'b1;
        tick();
        bus.sys_reset_ack = 1'b0;
        tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) bus.peripheral_reset = ~bus.peripheral_reset;
            if ($urandom_range(0, 9) == 0) begin
                bus.recovery_image_activated = ~bus.recovery_image_activated;
            end
            bus.escalated_reset = ($urandom_range(0, 31) == 0);
            bus.periph_ready    = ($urandom_range(0, 5) == 0);
            bus.sys_reset_ack   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) pulse_reset(1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
